gray_to_binary_serial: RTL and testbench

GRAY_TO_BINARY_SERIAL -- requirements
Module: gray_to_binary_serial

---
 rtl/gray_to_binary_serial_pkg.sv | 13 +
 rtl/gray_to_binary_serial_if.sv | 36 +++
 rtl/gray_to_binary_serial_step_check.sv | 27 ++
 rtl/gray_to_binary_serial.sv | 115 +++++++++++
 tb/tb_gray_to_binary_serial.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_to_binary_serial_pkg.sv
// Shared definitions for the serial Gray-to-binary converter: FSM states and
// the default word width.
package gray_to_binary_serial_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gray_to_binary_serial_if.sv
// Handshake bundle between a word producer/consumer and the serial converter.
interface gray_to_binary_serial_if
    import gray_to_binary_serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] G;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] B;
    logic         step_err;

    modport master (
        output in_valid,
        output G,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  B,
        input  step_err
    );

    modport slave (
        input  in_valid,
        input  G,
        input  out_ready,
        output in_ready,
        output out_valid,
        output B,
        output step_err
    );

endinterface

// File: rtl/gray_to_binary_serial_step_check.sv
// Combinational flag: the two words differ in more than one bit position.
module gray_step_check
    import gray_to_binary_serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         multi
);

    localparam int PW = $clog2(W + 1);

    logic [W-1:0]  diff_s;
    logic [PW-1:0] ones_s;

    // Population count of the differing bits.
    always_comb begin
        diff_s = a ^ b;
        ones_s = '0;
        for (int i = 0; i < W; i++) begin
            ones_s = ones_s + PW'(diff_s[i]);
        end
        multi = (ones_s > PW'(1));
    end

endmodule

// File: rtl/gray_to_binary_serial.sv
// Serial Gray-to-binary decoder: accepts one word, resolves one bit per cycle
// MSB first, then holds the result until the consumer takes it.
module gray_to_binary_serial
    import gray_to_binary_serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    gray_to_binary_serial_if.slave    bus
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  g_q, g_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q;
    logic          out_valid_q;

    logic          multi_s;
    logic [CW-1:0] idx_s;
    logic [W-1:0]  b_shift_s;

    gray_step_check #(.W(W)) u_step_check (
        .a     (bus.G),
        .b     (prev_q),
        .multi (multi_s)
    );

    // Unresolved bits are still 0, so the shifted result supplies a 0 above the MSB.
    assign b_shift_s = {1'b0, b_q[W-1:1]};
    assign idx_s     = LAST - cnt_q;

    // Next-state and datapath update for the IDLE/CONV/DONE sequence.
    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        b_d        = b_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d    = CONV;
                    g_d        = bus.G;
                    b_d        = '0;
                    cnt_d      = '0;
                    err_d      = prev_vld_q & multi_s;
                    prev_d     = bus.G;
                    prev_vld_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                b_d[idx_s] = b_shift_s[idx_s] ^ g_q[idx_s];
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = CONV;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            b_q         <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            b_q         <= b_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.B         = b_q;
    assign bus.step_err  = err_q;

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Self-checking bench for gray_to_binary_serial at W=4 and W=8.
module tb_gray_to_binary_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] prev4, prev8;
    logic        pv4, pv8;

    always #5 clk = ~clk;

    gray_to_binary_serial_if #(.W(4)) if4 ();
    gray_to_binary_serial_if #(.W(8)) if8 ();

    gray_to_binary_serial #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    gray_to_binary_serial #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    typedef struct {
        logic [3:0] g;
        logic [3:0] b;
        logic       err;
    } vec_t;

    // Binary value is the XOR of all right-shifts of the Gray code.
    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] r;
        r = g;
        for (int k = 1; k < 16; k++) r = r ^ (g >> k);
        return r;
    endfunction

    function automatic logic model_err(input logic [15:0] a, input logic [15:0] p, input logic pv);
        return pv && ($countones(a ^ p) > 1);
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 4) ? if4.in_ready : if8.in_ready;
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 4) ? if4.out_valid : if8.out_valid;
    endfunction

    function automatic logic [15:0] get_b(input int w);
        return (w == 4) ? {12'd0, if4.B} : {8'd0, if8.B};
    endfunction

    function automatic logic get_err(input int w);
        return (w == 4) ? if4.step_err : if8.step_err;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [15:0] g, input logic rdy);
        if (w == 4) begin
            if4.in_valid = v; if4.G = g[3:0]; if4.out_ready = rdy;
        end else begin
            if8.in_valid = v; if8.G = g[7:0]; if8.out_ready = rdy;
        end
    endtask

    // Accept one word, wait for out_valid, compare, release. Entered and left at a negedge.
    task automatic run_and_check(input int w, input logic [15:0] g, input logic [15:0] exp_b,
                                 input logic exp_e, input string name);
        int guard = 0;
        int lat   = 0;
        while (!get_ir(w) && guard < 50) begin @(negedge clk); guard++; end
        check({name, "_in_ready_wait"}, 32'(get_ir(w)), 32'd1);
        drive(w, 1'b1, g, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 16'd0, 1'b0);
        while (!get_ov(w) && lat < 40) begin @(negedge clk); lat++; end
        check({name, "_latency"},  32'(lat), 32'(w));
        check({name, "_B"},        32'(get_b(w)), 32'(exp_b));
        check({name, "_step_err"}, 32'(get_err(w)), 32'(exp_e));
        check({name, "_in_ready_low"}, 32'(get_ir(w)), 32'd0);
        drive(w, 1'b0, 16'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 16'd0, 1'b0);
        check({name, "_idle_in_ready"}, 32'(get_ir(w)), 32'd1);
        check({name, "_idle_out_valid"}, 32'(get_ov(w)), 32'd0);
        if (w == 4) begin prev4 = g; pv4 = 1'b1; end
        else        begin prev8 = g; pv8 = 1'b1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(if4.out_valid), 32'd0);
        check("reset_B",         32'(if4.B),         32'd0);
        check("reset_step_err",  32'(if4.step_err),  32'd0);
        rst = 1'b0;
        pv4 = 1'b0;
        pv8 = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(if4.in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] g;
        int   ov_seen;

        vecs[0] = '{g: 4'b0000, b: 4'b0000, err: 1'b0};
        vecs[1] = '{g: 4'b0001, b: 4'b0001, err: 1'b0};
        vecs[2] = '{g: 4'b0111, b: 4'b0101, err: 1'b1};
        vecs[3] = '{g: 4'b0111, b: 4'b0101, err: 1'b0};
        vecs[4] = '{g: 4'b0110, b: 4'b0100, err: 1'b0};
        vecs[5] = '{g: 4'b1010, b: 4'b1100, err: 1'b1};

        drive(4, 1'b0, 16'd0, 1'b0);
        drive(8, 1'b0, 16'd0, 1'b0);
        @(negedge clk);
        do_reset();

        // Basic decode of 0110 straight after reset.
        run_and_check(4, 16'b0110, 16'b0100, 1'b0, "basic");

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_and_check(4, {12'd0, vecs[i].g}, {12'd0, vecs[i].b}, vecs[i].err,
                          $sformatf("table%0d", i));
        end

        // Backpressure: result must hold while out_ready stays low and inputs wiggle.
        drive(4, 1'b1, 16'b0011, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 16'd0, 1'b0);
        for (int c = 0; c < 20 && !if4.out_valid; c++) @(negedge clk);
        check("bp_out_valid", 32'(if4.out_valid), 32'd1);
        check("bp_step_err",  32'(if4.step_err), 32'(model_err(16'b0011, prev4, pv4)));
        prev4 = 16'b0011;
        for (int c = 0; c < 5; c++) begin
            drive(4, c[0] ? 1'b0 : 1'b1, (c[1] ? 16'b1100 : 16'b1101), 1'b0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold_B%0d", c),  32'(if4.B),         32'(g2b(16'b0011)));
            check($sformatf("bp_hold_ir%0d", c), 32'(if4.in_ready),  32'd0);
            check($sformatf("bp_hold_ov%0d", c), 32'(if4.out_valid), 32'd1);
        end
        drive(4, 1'b1, 16'b1100, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 16'd0, 1'b0);
        check("bp_release_ir", 32'(if4.in_ready),  32'd1);
        check("bp_release_ov", 32'(if4.out_valid), 32'd0);
        // Same word again: any sneaked-in 110x acceptance would make this an error.
        run_and_check(4, 16'b0011, 16'b0010, 1'b0, "bp_after");

        // Reset in the middle of a conversion.
        drive(4, 1'b1, 16'b0110, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 16'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_partial_B", 32'(if4.B),         32'b0100);
        check("mid_no_ov",     32'(if4.out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ov",  32'(if4.out_valid), 32'd0);
        check("mid_rst_B",   32'(if4.B),         32'd0);
        check("mid_rst_err", 32'(if4.step_err),  32'd0);
        rst = 1'b0;
        pv4 = 1'b0;
        pv8 = 1'b0;
        @(negedge clk);
        check("mid_in_ready", 32'(if4.in_ready), 32'd1);
        ov_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (if4.out_valid) ov_seen++;
            @(negedge clk);
        end
        check("mid_ov_never", 32'(ov_seen), 32'd0);
        run_and_check(4, 16'b1001, 16'b1110, 1'b0, "mid_next");

        // Exhaustive W=4 sweep against the reference model.
        for (int i = 0; i < 16; i++) begin
            g = 16'(i);
            run_and_check(4, g, g2b(g), model_err(g, prev4, pv4), $sformatf("ex4_%0d", i));
        end

        // Random W=8 codes, including occasional repeats and single-bit steps.
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 3))
                0:       g = prev8;
                1:       g = prev8 ^ (16'd1 << $urandom_range(0, 7));
                default: g = 16'($urandom_range(0, 255));
            endcase
            run_and_check(8, g, g2b(g), model_err(g, prev8, pv8), $sformatf("rnd8_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
